// File: rtl/reward_pkg.sv
// Shared types and helpers for the reward update engine: FSM states, record
// field offsets and the signed saturating/wrapping add.
package reward_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWNode,
    StWClus,
    StRdQ,
    StWait,
    StWQ,
    StDone
  } state_e;

  localparam int unsigned NODE_OFS = 0;
  localparam int unsigned CLUS_OFS = 1;

  // Operands arrive sign-extended; the caller truncates the result to its width.
  function automatic logic signed [63:0] add_sat_wrap(input logic signed [63:0] a,
                                                      input logic signed [63:0] b,
                                                      input int unsigned        width,
                                                      input bit                 saturate);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (saturate && (sum > max_v)) return max_v;
    if (saturate && (sum < min_v)) return min_v;
    return sum;
  endfunction

endpackage

// File: rtl/reward_sat_add.sv
// Signed DW-bit adder for the Q-value update. Saturates when REWARD_SATURATE_EN
// is defined, otherwise wraps modulo 2^DW.
module reward_sat_add #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] sum_o
);
  import reward_pkg::*;

`ifdef REWARD_SATURATE_EN
  localparam bit Saturate = 1'b1;
`else
  localparam bit Saturate = 1'b0;
`endif

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;

  always_comb begin
    a_ext = 64'(signed'(a_i));
    b_ext = 64'(signed'(b_i));
    sum_o = DW'(add_sat_wrap(a_ext, b_ext, DW, Saturate));
  end

endmodule

// File: rtl/reward_update_engine.sv
// Writes a node record into the next-hop table and read-modify-writes the chosen Q-value
// over a single-port memory. Optional feature macro: REWARD_SATURATE_EN (see reward_sat_add).
module reward_update_engine #(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 16,
  parameter int unsigned REC_BASE   = 'h100,
  parameter int unsigned REC_STRIDE = 2,
  parameter int unsigned QTAB_BASE  = 'h400,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic          clock,
  input  logic          nrst,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] MY_NODE_ID,
  input  logic [DW-1:0] MY_CLUSTER_ID,
  input  logic [DW-1:0] action,
  input  logic [DW-1:0] besthop,
  input  logic [DW-1:0] reward,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data_out,
  output logic          rd_en,
  output logic          wr_en,
  output logic          busy,
  output logic          done
);
  import reward_pkg::*;

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   action_q, action_d;
  logic [DW-1:0]   besthop_q, besthop_d;
  logic [DW-1:0]   reward_q, reward_d;
  logic [DW-1:0]   clus_q, clus_d;
  logic [AW-1:0]   address_q, address_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   q_sum;

  // AW-bit arithmetic gives the required modulo-2^AW wrap directly.
  function automatic logic [AW-1:0] rec_addr(input logic [DW-1:0] hop);
    return AW'(REC_BASE) + AW'(hop) * AW'(REC_STRIDE);
  endfunction

  function automatic logic [AW-1:0] qtab_addr(input logic [DW-1:0] act);
    return AW'(QTAB_BASE) + AW'(act);
  endfunction

  reward_sat_add #(
    .DW(DW)
  ) u_sat_add (
    .a_i  (data_in),
    .b_i  (reward_q),
    .sum_o(q_sum)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    action_d   = action_q;
    besthop_d  = besthop_q;
    reward_d   = reward_q;
    clus_d     = clus_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && en) begin
          action_d   = action;
          besthop_d  = besthop;
          reward_d   = reward;
          clus_d     = MY_CLUSTER_ID;
          state_d    = StWNode;
          wr_en_d    = 1'b1;
          address_d  = rec_addr(besthop) + AW'(NODE_OFS);
          data_out_d = MY_NODE_ID;
        end
      end
      StWNode: begin
        state_d    = StWClus;
        wr_en_d    = 1'b1;
        address_d  = rec_addr(besthop_q) + AW'(CLUS_OFS);
        data_out_d = clus_q;
      end
      StWClus: begin
        state_d   = StRdQ;
        rd_en_d   = 1'b1;
        address_d = qtab_addr(action_q);
      end
      StRdQ: begin
        state_d = StWait;
        cnt_d   = CntW'(RD_LAT - 1);
      end
      StWait: begin
        // Read data is valid in the last WAIT cycle; fold it straight into the write word.
        if (cnt_q == '0) begin
          state_d    = StWQ;
          wr_en_d    = 1'b1;
          data_out_d = q_sum;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWQ: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_q != StIdle) && !en) begin
      state_d    = StIdle;
      cnt_d      = cnt_q;
      address_d  = address_q;
      data_out_d = data_out_q;
      rd_en_d    = 1'b0;
      wr_en_d    = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      action_q   <= '0;
      besthop_q  <= '0;
      reward_q   <= '0;
      clus_q     <= '0;
      address_q  <= '0;
      data_out_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      action_q   <= action_d;
      besthop_q  <= besthop_d;
      reward_q   <= reward_d;
      clus_q     <= clus_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign address  = address_q;
  assign data_out = data_out_q;
  assign rd_en    = rd_en_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reward_update_engine.sv
// Directed self-checking bench for reward_update_engine with a RD_LAT-deep memory read model.
module tb_reward_update_engine;

  localparam int unsigned AW     = 11;
  localparam int unsigned DW     = 16;
  localparam int unsigned RD_LAT = 2;

  logic          clock;
  logic          nrst;
  logic          en;
  logic          start;
  logic [DW-1:0] my_node_id;
  logic [DW-1:0] my_cluster_id;
  logic [DW-1:0] action;
  logic [DW-1:0] besthop;
  logic [DW-1:0] reward;
  logic [DW-1:0] data_in;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic          rd_en;
  logic          wr_en;
  logic          busy;
  logic          done;

  logic [DW-1:0]     mem_rdata;
  logic [RD_LAT-1:0] rd_pipe;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned done_cnt;
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  logic [AW-1:0] rd_a[$];

  reward_update_engine #(
    .AW        (AW),
    .DW        (DW),
    .REC_BASE  ('h100),
    .REC_STRIDE(2),
    .QTAB_BASE ('h400),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clock        (clock),
    .nrst         (nrst),
    .en           (en),
    .start        (start),
    .MY_NODE_ID   (my_node_id),
    .MY_CLUSTER_ID(my_cluster_id),
    .action       (action),
    .besthop      (besthop),
    .reward       (reward),
    .data_in      (data_in),
    .address      (address),
    .data_out     (data_out),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Read data is only valid exactly RD_LAT cycles after rd_en; garbage otherwise.
  always @(posedge clock or negedge nrst) begin
    if (!nrst) rd_pipe <= '0;
    else       rd_pipe <= {rd_pipe[RD_LAT-2:0], rd_en};
  end
  assign data_in = rd_pipe[RD_LAT-1] ? mem_rdata : 16'hDEAD;

  always @(negedge clock) begin
    if (nrst) begin
      if (wr_en) begin
        wr_a.push_back(address);
        wr_d.push_back(data_out);
      end
      if (rd_en) rd_a.push_back(address);
      if (done) done_cnt++;
    end
  end

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    done_cnt = 0;
  endtask

  task automatic start_op(input logic [DW-1:0] hop, input logic [DW-1:0] act,
                          input logic [DW-1:0] rew, input logic [DW-1:0] rdata);
    @(negedge clock);
    #1;
    clear_log();
    besthop   = hop;
    action    = act;
    reward    = rew;
    mem_rdata = rdata;
    en        = 1'b1;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #2;
    n_cmp++;
    if ({address, data_out, rd_en, wr_en, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got a=%h d=%h rd=%b wr=%b busy=%b done=%b want all 0",
               address, data_out, rd_en, wr_en, busy, done);
    end
    @(negedge clock);
    @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({busy, rd_en, wr_en} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b rd=%b wr=%b want 000", busy, rd_en, wr_en);
    end
  endtask

  task automatic test_basic();
    start_op(16'd3, 16'd5, 16'h0005, 16'h0010);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({busy, done, wr_en, rd_en} !== {k <= 7, k == 7, k == 1 || k == 2 || k == 6, k == 3})
      begin
        n_err++;
        $display("FAIL basic_timing k=%0d: got busy/done/wr/rd=%b%b%b%b want %b%b%b%b", k,
                 busy, done, wr_en, rd_en, k <= 7, k == 7, k == 1 || k == 2 || k == 6, k == 3);
      end
    end
    #1;
    n_cmp++;
    if (wr_a.size() !== 3 || rd_a.size() !== 1 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL basic_counts: got wr=%0d rd=%0d done=%0d want 3 1 1",
               wr_a.size(), rd_a.size(), done_cnt);
    end else begin
      n_cmp++;
      if (wr_a[0] !== 11'h106 || wr_d[0] !== 16'hA1B2) begin
        n_err++;
        $display("FAIL basic_w_node: got %h=%h want 106=a1b2", wr_a[0], wr_d[0]);
      end
      n_cmp++;
      if (wr_a[1] !== 11'h107 || wr_d[1] !== 16'hC3D4) begin
        n_err++;
        $display("FAIL basic_w_clus: got %h=%h want 107=c3d4", wr_a[1], wr_d[1]);
      end
      n_cmp++;
      if (rd_a[0] !== 11'h405) begin
        n_err++;
        $display("FAIL basic_rd_q: got %h want 405", rd_a[0]);
      end
      n_cmp++;
      if (wr_a[2] !== 11'h405 || wr_d[2] !== 16'h0015) begin
        n_err++;
        $display("FAIL basic_w_q: got %h=%h want 405=0015", wr_a[2], wr_d[2]);
      end
    end
  endtask

  task automatic test_arith(input logic [DW-1:0] rdata, input logic [DW-1:0] rew,
                            input logic [DW-1:0] exp_q);
    start_op(16'd1, 16'h0010, rew, rdata);
    repeat (8) @(negedge clock);
    #1;
    n_cmp++;
    if (wr_d.size() !== 3) begin
      n_err++;
      $display("FAIL arith_count: got %0d writes want 3", wr_d.size());
    end else if (wr_a[2] !== 11'h410 || wr_d[2] !== exp_q) begin
      n_err++;
      $display("FAIL arith_%h_%h: got %h=%h want 410=%h", rdata, rew, wr_a[2], wr_d[2], exp_q);
    end
  endtask

  task automatic test_abort();
    start_op(16'd2, 16'd7, 16'h0001, 16'h0100);
    repeat (5) @(negedge clock);
    en = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({busy, done, wr_en, rd_en} !== 4'b0000) begin
        n_err++;
        $display("FAIL abort_k%0d: got busy/done/wr/rd=%b%b%b%b want 0000", k,
                 busy, done, wr_en, rd_en);
      end
    end
    #1;
    n_cmp++;
    if (wr_a.size() !== 2 || done_cnt !== 0) begin
      n_err++;
      $display("FAIL abort_log: got writes=%0d done=%0d want 2 0", wr_a.size(), done_cnt);
    end
    en = 1'b1;
  endtask

  task automatic test_start_ignored();
    start_op(16'd4, 16'd1, 16'h0002, 16'h0003);
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    #1;
    n_cmp++;
    if (wr_a.size() !== 3 || rd_a.size() !== 1 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL busy_start: got wr=%0d rd=%0d done=%0d want 3 1 1",
               wr_a.size(), rd_a.size(), done_cnt);
    end
    clear_log();
    en    = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({busy, wr_en, rd_en} !== 3'b000) begin
        n_err++;
        $display("FAIL en_low_start k=%0d: got busy/wr/rd=%b%b%b want 000", k, busy, wr_en, rd_en);
      end
    end
    start = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset_mid();
    start_op(16'd3, 16'd5, 16'h0005, 16'h0010);
    repeat (2) @(negedge clock);
    n_cmp++;
    if (wr_en !== 1'b1 || address !== 11'h107) begin
      n_err++;
      $display("FAIL rst_mid_pre: got wr=%b a=%h want 1 107", wr_en, address);
    end
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, busy, address, data_out} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_now: got wr=%b busy=%b a=%h d=%h want all 0",
               wr_en, busy, address, data_out);
    end
    @(negedge clock);
    nrst = 1'b1;
    #1 clear_log();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({busy, wr_en, rd_en, done} !== 4'b0000) begin
        n_err++;
        $display("FAIL rst_mid_after k=%0d: got busy/wr/rd/done=%b%b%b%b want 0000", k,
                 busy, wr_en, rd_en, done);
      end
    end
  endtask

  task automatic test_wrap();
    start_op(16'h03FF, 16'h03FF, 16'h0001, 16'h0001);
    repeat (8) @(negedge clock);
    #1;
    n_cmp++;
    if (wr_a.size() !== 3 || rd_a.size() !== 1) begin
      n_err++;
      $display("FAIL wrap_counts: got wr=%0d rd=%0d want 3 1", wr_a.size(), rd_a.size());
    end else begin
      n_cmp++;
      if (wr_a[0] !== 11'h0FE || wr_a[1] !== 11'h0FF) begin
        n_err++;
        $display("FAIL wrap_rec: got %h %h want 0fe 0ff", wr_a[0], wr_a[1]);
      end
      n_cmp++;
      if (rd_a[0] !== 11'h7FF || wr_a[2] !== 11'h7FF || wr_d[2] !== 16'h0002) begin
        n_err++;
        $display("FAIL wrap_q: got rd=%h wr=%h=%h want 7ff 7ff=0002", rd_a[0], wr_a[2], wr_d[2]);
      end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    done_cnt      = 0;
    en            = 1'b1;
    start         = 1'b0;
    my_node_id    = 16'hA1B2;
    my_cluster_id = 16'hC3D4;
    action        = '0;
    besthop       = '0;
    reward        = '0;
    mem_rdata     = '0;

    test_reset();
    test_basic();
`ifdef REWARD_SATURATE_EN
    test_arith(16'h7FF0, 16'h0020, 16'h7FFF);
    test_arith(16'h8005, 16'hFFF0, 16'h8000);
`else
    test_arith(16'h7FF0, 16'h0020, 16'h8010);
    test_arith(16'h8005, 16'hFFF0, 16'h7FF5);
`endif
    test_arith(16'h0100, 16'hFFFF, 16'h00FF);
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
